mcu_sequencer: RTL

// - Sequences the entropy decoding datapath through an image's MCU structure.
// - Counts decoded blocks (one blk_done pulse per 8x8 block from the decoder) and tracks:

---
 rtl/mcu_sequencer.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/mcu_sequencer.sv
// Purpose : walks components, blocks and MCUs of a frame; tells the entropy decoder where it is and when to clear DC predictors.
// Latency : 1 cycle from blk_done or an accepted cfg_valid to the updated, fully registered outputs.
// Backpressure: none; blk_done may pulse every cycle in RUN and is ignored elsewhere. Optional macro RESTART_EN adds restart-interval handling.
module mcu_sequencer #(
  parameter int CH      = 3,
  parameter int MAX_BPC = 4,
  parameter int DIM_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_valid,
  input  logic [CH-1:0][2:0]      cfg_blocks,
  input  logic [DIM_W-1:0]        cfg_mcus_per_row,
  input  logic [DIM_W-1:0]        cfg_mcu_rows,
  input  logic [DIM_W-1:0]        cfg_rst_interval,
  input  logic                    blk_done,
  output logic [$clog2(CH+1)-1:0] ch,
  output logic [1:0]              blk_idx,
  output logic [DIM_W-1:0]        mcu_x,
  output logic [DIM_W-1:0]        mcu_y,
  output logic                    dc_clr,
  output logic                    rst_marker,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    cfg_err
);

  localparam int CH_W = $clog2(CH+1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CH-1:0][2:0] blocks_q, blocks_d;
  logic [DIM_W-1:0]   mpr_q, mpr_d;
  logic [DIM_W-1:0]   rows_q, rows_d;
  logic [CH_W-1:0]    ch_d;
  logic [1:0]         blk_idx_d;
  logic [DIM_W-1:0]   mcu_x_d, mcu_y_d;
  logic               dc_clr_d, rst_marker_d, busy_d, frame_done_d, cfg_err_d;

  logic               cfg_ok;
  logic               last_blk;
  logic               last_x, last_y;
  logic               nxt_found;
  logic [CH_W-1:0]    nxt_ch;

`ifdef RESTART_EN
  logic [DIM_W-1:0]   rint_q, rint_d;
  logic [DIM_W-1:0]   rcnt_q, rcnt_d;
`else
  logic               unused_rst_interval;
  assign unused_rst_interval = ^cfg_rst_interval;
`endif

  // Configuration check: luma must be present, every component within the block limit, non-empty frame.
  always_comb begin
    cfg_ok = (cfg_blocks[0] != 3'd0) && (int'(cfg_blocks[0]) <= MAX_BPC) &&
             (cfg_mcus_per_row != '0) && (cfg_mcu_rows != '0);
    for (int c = 1; c < CH; c++) begin
      if (int'(cfg_blocks[c]) > MAX_BPC) cfg_ok = 1'b0;
    end
  end

  // Lowest present component above the one in flight; absent components are skipped.
  always_comb begin
    nxt_found = 1'b0;
    nxt_ch    = '0;
    for (int c = CH - 1; c >= 0; c--) begin
      if ((c > int'(ch)) && (blocks_q[c] != 3'd0)) begin
        nxt_found = 1'b1;
        nxt_ch    = CH_W'(c);
      end
    end
  end

  assign last_blk = ({1'b0, blk_idx} == (blocks_q[ch] - 3'd1));
  assign last_x   = (mcu_x == (mpr_q - DIM_W'(1)));
  assign last_y   = (mcu_y == (rows_q - DIM_W'(1)));

  // Next-state and next-output logic; the last block's position is held through DONE and IDLE.
  always_comb begin
    state_d      = state_q;
    blocks_d     = blocks_q;
    mpr_d        = mpr_q;
    rows_d       = rows_q;
    ch_d         = ch;
    blk_idx_d    = blk_idx;
    mcu_x_d      = mcu_x;
    mcu_y_d      = mcu_y;
    dc_clr_d     = 1'b0;
    rst_marker_d = 1'b0;
    frame_done_d = 1'b0;
    cfg_err_d    = 1'b0;
`ifdef RESTART_EN
    rint_d       = rint_q;
    rcnt_d       = rcnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cfg_valid) begin
          if (cfg_ok) begin
            state_d   = S_RUN;
            blocks_d  = cfg_blocks;
            mpr_d     = cfg_mcus_per_row;
            rows_d    = cfg_mcu_rows;
            ch_d      = '0;
            blk_idx_d = '0;
            mcu_x_d   = '0;
            mcu_y_d   = '0;
            dc_clr_d  = 1'b1;
`ifdef RESTART_EN
            rint_d    = cfg_rst_interval;
            rcnt_d    = '0;
`endif
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (blk_done) begin
          if (!last_blk) begin
            blk_idx_d = blk_idx + 2'd1;
          end else if (nxt_found) begin
            blk_idx_d = '0;
            ch_d      = nxt_ch;
          end else if (last_x && last_y) begin
            state_d      = S_DONE;
            frame_done_d = 1'b1;
          end else begin
            blk_idx_d = '0;
            ch_d      = '0;
            if (last_x) begin
              mcu_x_d = '0;
              mcu_y_d = mcu_y + DIM_W'(1);
            end else begin
              mcu_x_d = mcu_x + DIM_W'(1);
            end
`ifdef RESTART_EN
            if ((rint_q != '0) && ((rcnt_q + DIM_W'(1)) == rint_q)) begin
              dc_clr_d     = 1'b1;
              rst_marker_d = 1'b1;
              rcnt_d       = '0;
            end else begin
              rcnt_d       = rcnt_q + DIM_W'(1);
            end
`endif
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN);
  end

  // State, latched configuration and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      blocks_q   <= '0;
      mpr_q      <= '0;
      rows_q     <= '0;
      ch         <= '0;
      blk_idx    <= '0;
      mcu_x      <= '0;
      mcu_y      <= '0;
      dc_clr     <= 1'b0;
      rst_marker <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      blocks_q   <= blocks_d;
      mpr_q      <= mpr_d;
      rows_q     <= rows_d;
      ch         <= ch_d;
      blk_idx    <= blk_idx_d;
      mcu_x      <= mcu_x_d;
      mcu_y      <= mcu_y_d;
      dc_clr     <= dc_clr_d;
      rst_marker <= rst_marker_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
      cfg_err    <= cfg_err_d;
    end
  end

`ifdef RESTART_EN
  // Restart-interval bookkeeping: MCUs completed since the last restart point.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rint_q <= '0;
      rcnt_q <= '0;
    end else begin
      rint_q <= rint_d;
      rcnt_q <= rcnt_d;
    end
  end
`endif

endmodule
